// File: rtl/rv_mc_core.sv
// rv_mc_core: multi-cycle RV32I-subset core (OP-IMM, LUI, AUIPC, JAL, JALR, EBREAK).
// Each instruction takes one fetch-request state, one fetch-wait state and one
// execute state. The core halts on ebreak or any illegal instruction.
//
// Parameters
//   RF_ADDR_W     register index width (5 = RV32I, 4 = RV32E)
//   RESET_PC      PC loaded on reset
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   imem_req_valid/ready         fetch request handshake
//   imem_addr                    fetch address (current PC)
//   imem_rsp_valid/data          fetched instruction word
//   commit_valid/pc/rd/wdata     registered one-cycle retire record
//   halted, halt_code            sticky stop flag and a0 (or all-ones if illegal)
module rv_mc_core #(
  parameter int unsigned RF_ADDR_W = 5,
  parameter logic [31:0] RESET_PC  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_wdata,
  output logic        halted,
  output logic [31:0] halt_code
);

  localparam int unsigned NREGS = 1 << RF_ADDR_W;

  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [6:0]  OP_SYS   = 7'b1110011;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  typedef enum logic [1:0] {S_IF_REQ, S_IF_WAIT, S_EXEC, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        commit_valid_q, commit_valid_d;
  logic [31:0] commit_pc_q, commit_pc_d;
  logic [4:0]  commit_rd_q, commit_rd_d;
  logic [31:0] commit_wdata_q, commit_wdata_d;
  logic        halted_q, halted_d;
  logic [31:0] halt_code_q, halt_code_d;

  logic [31:0] rf_q [NREGS];
  logic        rf_we;

  // ---------------------------------------------------------------- decode
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd_idx, rs1_idx, shamt;
  logic [31:0] imm_i, imm_u, imm_j, rs1_val;

  assign opcode  = ir_q[6:0];
  assign rd_idx  = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign rs1_idx = ir_q[19:15];
  assign shamt   = ir_q[24:20];
  assign funct7  = ir_q[31:25];
  assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u   = {ir_q[31:12], 12'b0};
  assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign rs1_val = (rs1_idx == 5'd0) ? 32'd0 : rf_q[rs1_idx[RF_ADDR_W-1:0]];

  // Register index beyond the implemented file (only possible in RV32E mode).
  function automatic logic idx_oob(input logic [4:0] idx);
    return {27'b0, idx} >= NREGS;
  endfunction

  // --------------------------------------------------------------- execute
  logic [31:0] result, next_pc, target;
  logic        illegal, is_ebreak;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave it unassigned and infer a latch.
  always_comb begin
    result    = 32'd0;
    next_pc   = pc_q + 32'd4;
    target    = 32'd0;
    illegal   = 1'b0;
    is_ebreak = 1'b0;
    case (opcode)
      OP_IMM: begin
        illegal = idx_oob(rs1_idx) || idx_oob(rd_idx);
        case (funct3)
          3'b000: result = rs1_val + imm_i;
          3'b010: result = {31'b0, $signed(rs1_val) < $signed(imm_i)};
          3'b011: result = {31'b0, rs1_val < imm_i};
          3'b100: result = rs1_val ^ imm_i;
          3'b110: result = rs1_val | imm_i;
          3'b111: result = rs1_val & imm_i;
          3'b001: begin
            result = rs1_val << shamt;
            if (funct7 != 7'b0000000) illegal = 1'b1;
          end
          default: begin  // 3'b101: srli / srai selected by funct7
            if (funct7 == 7'b0000000)      result = rs1_val >> shamt;
            else if (funct7 == 7'b0100000) result = $unsigned($signed(rs1_val) >>> shamt);
            else                           illegal = 1'b1;
          end
        endcase
      end
      OP_LUI: begin
        result  = imm_u;
        illegal = idx_oob(rd_idx);
      end
      OP_AUIPC: begin
        result  = pc_q + imm_u;
        illegal = idx_oob(rd_idx);
      end
      OP_JAL: begin
        result  = pc_q + 32'd4;
        target  = pc_q + imm_j;
        next_pc = target;
        illegal = idx_oob(rd_idx) || target[1];
      end
      OP_JALR: begin
        result  = pc_q + 32'd4;
        target  = (rs1_val + imm_i) & ~32'd1;
        next_pc = target;
        illegal = (funct3 != 3'b000) || idx_oob(rs1_idx) || idx_oob(rd_idx) || target[1];
      end
      OP_SYS: begin
        if (ir_q == EBREAK) is_ebreak = 1'b1;
        else                illegal   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // ------------------------------------------------------------------- FSM
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    commit_valid_d = 1'b0;
    commit_pc_d    = commit_pc_q;
    commit_rd_d    = commit_rd_q;
    commit_wdata_d = commit_wdata_q;
    halted_d       = halted_q;
    halt_code_d    = halt_code_q;
    rf_we          = 1'b0;
    case (state_q)
      S_IF_REQ: if (imem_req_ready) state_d = S_IF_WAIT;
      S_IF_WAIT: begin
        if (imem_rsp_valid) begin
          ir_d    = imem_rsp_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        commit_valid_d = 1'b1;
        commit_pc_d    = pc_q;
        if (illegal || is_ebreak) begin
          commit_rd_d    = 5'd0;
          commit_wdata_d = 32'd0;
          halted_d       = 1'b1;
          halt_code_d    = illegal ? 32'hFFFF_FFFF : rf_q[RF_ADDR_W'(10)];
          state_d        = S_HALT;
        end else begin
          commit_rd_d    = rd_idx;
          commit_wdata_d = (rd_idx == 5'd0) ? 32'd0 : result;
          rf_we          = (rd_idx != 5'd0);
          pc_d           = next_pc;
          state_d        = S_IF_REQ;
        end
      end
      default: ;  // S_HALT: frozen until reset
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IF_REQ;
      pc_q           <= RESET_PC;
      ir_q           <= 32'd0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= 32'd0;
      commit_rd_q    <= 5'd0;
      commit_wdata_q <= 32'd0;
      halted_q       <= 1'b0;
      halt_code_q    <= 32'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      commit_rd_q    <= commit_rd_d;
      commit_wdata_q <= commit_wdata_d;
      halted_q       <= halted_d;
      halt_code_q    <= halt_code_d;
    end
  end

  // NOTE: the register file is built from flops with reset because every
  // register must read 0 after reset; a RAM macro could not provide that.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= 32'd0;
    end else if (rf_we) begin
      rf_q[rd_idx[RF_ADDR_W-1:0]] <= commit_wdata_d;
    end
  end

  // Gated by rst so no request is visible while reset is held.
  assign imem_req_valid = (state_q == S_IF_REQ) && rst;
  assign imem_addr      = pc_q;
  assign commit_valid   = commit_valid_q;
  assign commit_pc      = commit_pc_q;
  assign commit_rd      = commit_rd_q;
  assign commit_wdata   = commit_wdata_q;
  assign halted         = halted_q;
  assign halt_code      = halt_code_q;

endmodule

// File: tb/tb_rv_mc_core.sv
// Directed bench for rv_mc_core: one RV32I instance and one RV32E instance
// share the memory-side inputs; each is held in reset while the other runs.
module tb_rv_mc_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_m, rst_e, sel;
  logic        imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  logic        m_req_valid, e_req_valid, m_cv, e_cv, m_halted, e_halted;
  logic [31:0] m_addr, e_addr, m_cpc, e_cpc, m_cwd, e_cwd, m_hc, e_hc;
  logic [4:0]  m_crd, e_crd;

  rv_mc_core dut (
    .clk(clk), .rst(rst_m),
    .imem_req_valid(m_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(m_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .commit_valid(m_cv), .commit_pc(m_cpc), .commit_rd(m_crd), .commit_wdata(m_cwd),
    .halted(m_halted), .halt_code(m_hc)
  );

  rv_mc_core #(.RF_ADDR_W(4)) dut_e (
    .clk(clk), .rst(rst_e),
    .imem_req_valid(e_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(e_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .commit_valid(e_cv), .commit_pc(e_cpc), .commit_rd(e_crd), .commit_wdata(e_cwd),
    .halted(e_halted), .halt_code(e_hc)
  );

  // Observed core selected by sel (0 = RV32I, 1 = RV32E).
  logic        o_req_valid, o_cv, o_halted;
  logic [31:0] o_addr, o_cpc, o_cwd, o_hc;
  logic [4:0]  o_crd;
  always_comb begin
    o_req_valid = sel ? e_req_valid : m_req_valid;
    o_addr      = sel ? e_addr      : m_addr;
    o_cv        = sel ? e_cv        : m_cv;
    o_cpc       = sel ? e_cpc       : m_cpc;
    o_crd       = sel ? e_crd       : m_crd;
    o_cwd       = sel ? e_cwd       : m_cwd;
    o_halted    = sel ? e_halted    : m_halted;
    o_hc        = sel ? e_hc        : m_hc;
  end

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int commit_cnt = 0;
  always @(posedge clk) begin
    cyc++;
    if (o_cv) commit_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!o_req_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!o_req_valid) check({tag, " req timeout"}, 32'd0, 32'd1);
  endtask

  // One instruction with zero-stall handshake; checks the retire record and
  // the 3-cycle latency. Returns at the negedge of the commit cycle.
  task automatic fetch(input string tag, input logic [31:0] instr, input logic [31:0] exp_pc,
                       input logic [4:0] exp_rd, input logic [31:0] exp_wd);
    int t0;
    wait_req(tag);
    check({tag, " addr"}, o_addr, exp_pc);
    t0 = cyc;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = instr;
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    @(negedge clk);
    check({tag, " commit_valid"}, {31'b0, o_cv}, 32'd1);
    check({tag, " commit_pc"}, o_cpc, exp_pc);
    check({tag, " commit_rd"}, {27'b0, o_crd}, {27'b0, exp_rd});
    check({tag, " commit_wdata"}, o_cwd, exp_wd);
    check({tag, " latency"}, cyc - t0, 32'd3);
  endtask

  task automatic do_reset(input logic which_e);
    @(negedge clk);
    sel = which_e;
    if (which_e) rst_e = 1'b0; else rst_m = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    #1;
    check("rst req_valid", {31'b0, o_req_valid}, 32'd0);
    check("rst commit_valid", {31'b0, o_cv}, 32'd0);
    check("rst commit_pc", o_cpc, 32'd0);
    check("rst halted", {31'b0, o_halted}, 32'd0);
    check("rst halt_code", o_hc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    if (which_e) rst_e = 1'b1; else rst_m = 1'b1;
    #1;
    check("post-rst req_valid", {31'b0, o_req_valid}, 32'd1);
    check("post-rst addr", o_addr, 32'h8000_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, t0, c0;
    rst_m = 1'b0; rst_e = 1'b0; sel = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;

    // ---- ALU / upper-immediate stream on RV32I core
    do_reset(1'b0);
    fetch("addi x1",  32'h0050_0093, 32'h8000_0000, 5'd1, 32'd5);
    check("back-to-back req", {31'b0, o_req_valid}, 32'd1);
    fetch("addi x2",  32'hFFD0_8113, 32'h8000_0004, 5'd2, 32'd2);
    fetch("auipc x4", 32'h0000_1217, 32'h8000_0008, 5'd4, 32'h8000_1008);
    fetch("lui x3",   32'h1234_51B7, 32'h8000_000C, 5'd3, 32'h1234_5000);
    fetch("srai x5",  32'h4041_D293, 32'h8000_0010, 5'd5, 32'h0123_4500);
    fetch("sltiu x6", 32'hFFF0_3313, 32'h8000_0014, 5'd6, 32'd1);
    fetch("xori x7",  32'hFFF2_C393, 32'h8000_0018, 5'd7, 32'hFEDC_BAFF);
    fetch("slti x8",  32'h0003_A413, 32'h8000_001C, 5'd8, 32'd1);
    fetch("srli x9",  32'h01C3_D493, 32'h8000_0020, 5'd9, 32'h0000_000F);

    // ---- jumps, then ebreak halt
    do_reset(1'b0);
    fetch("jal x1",      32'h0100_00EF, 32'h8000_0000, 5'd1, 32'h8000_0004);
    fetch("addi x1+1",   32'h0010_8093, 32'h8000_0010, 5'd1, 32'h8000_0005);
    fetch("jalr x0",     32'h0000_8067, 32'h8000_0014, 5'd0, 32'd0);
    fetch("addi x10",    32'h02A0_0513, 32'h8000_0004, 5'd10, 32'd42);
    fetch("ebreak",      32'h0010_0073, 32'h8000_0008, 5'd0, 32'd0);
    check("ebreak halted", {31'b0, o_halted}, 32'd1);
    check("ebreak halt_code", o_hc, 32'd42);
    bad = 0;
    c0 = commit_cnt;
    imem_req_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (o_req_valid) bad++;
    end
    imem_req_ready = 1'b0;
    check("halt no requests", bad, 32'd0);
    check("halt single commit", commit_cnt - c0, 32'd1);
    check("halt sticky", {31'b0, o_halted}, 32'd1);

    // ---- stalled handshake; response during IF_REQ must be ignored
    do_reset(1'b0);
    t0 = cyc; c0 = commit_cnt; bad = 0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0073;
    repeat (4) begin
      @(negedge clk);
      if (o_addr !== 32'h8000_0000 || !o_req_valid) bad++;
    end
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; imem_rsp_data = 32'h0070_0093;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("wait no req", {31'b0, o_req_valid}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (o_addr !== 32'h8000_0000 || o_req_valid) bad++;
    end
    imem_rsp_valid = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    check("stall addr stable", bad, 32'd0);
    check("stall commit_valid", {31'b0, o_cv}, 32'd1);
    check("stall commit_pc", o_cpc, 32'h8000_0000);
    check("stall commit_wdata", o_cwd, 32'd7);
    check("stall latency", cyc - t0, 32'd10);
    @(negedge clk);
    check("commit one-cycle pulse", {31'b0, o_cv}, 32'd0);
    repeat (2) @(negedge clk);
    check("stall commit count", commit_cnt - c0, 32'd1);
    check("stall next addr", o_addr, 32'h8000_0004);

    // ---- RV32E core: out-of-range register is illegal
    rst_m = 1'b0;
    do_reset(1'b1);
    fetch("e addi x1",  32'h0030_0093, 32'h8000_0000, 5'd1, 32'd3);
    fetch("e addi x16", 32'h0010_0813, 32'h8000_0004, 5'd0, 32'd0);
    check("e illegal halted", {31'b0, o_halted}, 32'd1);
    check("e illegal halt_code", o_hc, 32'hFFFF_FFFF);
    do_reset(1'b1);

    // Reset asserted mid-fetch (IF_WAIT); a late response lands in IF_REQ.
    wait_req("e midrst");
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst_e = 1'b0;
    #1;
    check("midrst req_valid", {31'b0, o_req_valid}, 32'd0);
    check("midrst halted", {31'b0, o_halted}, 32'd0);
    @(negedge clk);
    rst_e = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0073;
    #1;
    check("midrst addr", o_addr, 32'h8000_0000);
    @(negedge clk);
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    check("midrst still requesting", {31'b0, o_req_valid}, 32'd1);
    fetch("e after midrst", 32'h0090_0093, 32'h8000_0000, 5'd1, 32'd9);
    check("e after midrst halted", {31'b0, o_halted}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
